// File: rtl/ram_display_ctrl.sv
// Word RAM with a seven-segment viewer: shows the address or the stored word in decimal or hex,
// with leading-zero blanking. A double-dabble engine converts the value and digits refresh on change.
module ram_display_ctrl #(
    parameter int AW   = 4,
    parameter int DW   = 8,
    parameter int NDIG = 6
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [AW-1:0]     address,
    input  logic [DW-1:0]     data_in,
    input  logic              we,
    input  logic              mode,
    input  logic              hex_mode,
    output logic [NDIG*8-1:0] seg,
    output logic              busy,
    output logic              overflow
);
    // state   | meaning
    // IDLE    | watch {mode,hex_mode,value} against shadow, wait for change or pending refresh
    // LOAD    | capture shadow and operand, clear BCD scratch
    // CONVERT | double-dabble steps (decimal) or direct nibble copy (hex)
    // UPDATE  | encode glyphs, register seg and overflow

    localparam int W  = (AW > DW) ? AW : DW;
    localparam int NB = (W + 2) / 3;
    localparam int ND = (NB > NDIG) ? NB : NDIG;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CONVERT, UPDATE} state_t;

    logic [DW-1:0]     mem_q [2**AW];
    logic [DW-1:0]     rdata_q;
    logic [W-1:0]      v;
    logic [W+1:0]      key;
    state_t            state_q;
    logic [W+1:0]      shadow_q;
    logic              pend_q;
    logic [W-1:0]      bin_q;
    logic [4*ND-1:0]   bcd_q;
    logic [4*ND-1:0]   bcd_adj;
    logic [4*ND-1:0]   bcd_dd;
    logic [CW-1:0]     cnt_q;
    logic [NDIG*8-1:0] seg_q;
    logic [NDIG*8-1:0] seg_d;
    logic              busy_q;
    logic              ovf_q;
    logic              ovf_d;
    logic [ND-1:0]     lit;

    function automatic logic [7:0] glyph(input logic [3:0] n, input logic hx);
        logic [7:0] g;
        case (n)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            4'd10:   g = hx ? 8'h88 : 8'hFF;
            4'd11:   g = hx ? 8'h83 : 8'hFF;
            4'd12:   g = hx ? 8'hC6 : 8'hFF;
            4'd13:   g = hx ? 8'hA1 : 8'hFF;
            4'd14:   g = hx ? 8'h86 : 8'hFF;
            default: g = hx ? 8'h8E : 8'hFF;
        endcase
        return g;
    endfunction

    // RAM is outside reset; the read is registered and sees the pre-write contents
    always_ff @(posedge clock_in) begin
        if (we) mem_q[address] <= data_in;
        rdata_q <= mem_q[address];
    end

    assign v   = mode ? W'(address) : W'(rdata_q);
    assign key = {mode, hex_mode, v};

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_dd = {bcd_adj[4*ND-2:0], bin_q[W-1]};
    end

    // Blanking looks at all converted digits, so low digits stay lit when the value overflows
    always_comb begin
        logic seen;
        seen  = 1'b0;
        ovf_d = 1'b0;
        lit   = '0;
        seg_d = '1;
        for (int i = ND - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
            if (i >= NDIG && bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
            lit[i] = seen || (i == 0);
        end
        for (int i = 0; i < NDIG; i++) begin
            if (lit[i]) seg_d[8*i +: 8] = glyph(bcd_q[4*i +: 4], shadow_q[W]);
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= 1'b1;
            shadow_q <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            seg_q    <= '1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key != shadow_q || pend_q) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    shadow_q <= key;
                    bin_q    <= v;
                    bcd_q    <= '0;
                    pend_q   <= 1'b0;
                    cnt_q    <= CW'(W - 1);
                    state_q  <= CONVERT;
                end
                CONVERT: begin
                    if (shadow_q[W]) begin
                        bcd_q   <= (4*ND)'(bin_q);
                        state_q <= UPDATE;
                    end else begin
                        bcd_q <= bcd_dd;
                        bin_q <= bin_q << 1;
                        if (cnt_q == '0) state_q <= UPDATE;
                        else             cnt_q   <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    seg_q   <= seg_d;
                    ovf_q   <= ovf_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign seg      = seg_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ram_display_ctrl.sv
// Bench for ram_display_ctrl: a 6-digit and a 2-digit instance share stimulus; expectations come
// from an arithmetic digit model, queued at drive time and compared once the display settles.
module tb_ram_display_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic [7:0]  data_in;
    logic        we, mode, hex_mode;
    logic [47:0] seg6;
    logic [15:0] seg2;
    logic        busy6, busy2, ovf6, ovf2;

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_m [16];

    typedef struct {
        logic [63:0] s6;
        logic        o6;
        logic [63:0] s2;
        logic        o2;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        m;
        logic        h;
        logic [3:0]  a;
        logic [7:0]  d;
        exp_t        e;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    ram_display_ctrl #(.AW(4), .DW(8), .NDIG(6)) dut (
        .clock_in(clk), .reset(reset), .address(address), .data_in(data_in), .we(we),
        .mode(mode), .hex_mode(hex_mode), .seg(seg6), .busy(busy6), .overflow(ovf6));

    ram_display_ctrl #(.AW(4), .DW(8), .NDIG(2)) dut2 (
        .clock_in(clk), .reset(reset), .address(address), .data_in(data_in), .we(we),
        .mode(mode), .hex_mode(hex_mode), .seg(seg2), .busy(busy2), .overflow(ovf2));

    function automatic logic [7:0] tglyph(input int unsigned d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
            12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [63:0] model_seg(input int unsigned v, input bit hx, input int nd);
        logic [63:0] r;
        int unsigned rem, base;
        r    = '1;
        rem  = v;
        base = hx ? 16 : 10;
        for (int i = 0; i < nd; i++) begin
            if (i == 0 || rem != 0) r[8*i +: 8] = tglyph(rem % base);
            rem = rem / base;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned v, input bit hx, input int nd);
        longint p;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * (hx ? 16 : 10);
        return longint'(v) >= p;
    endfunction

    function automatic exp_t model(input int unsigned v, input bit hx);
        exp_t e;
        e.s6 = model_seg(v, hx, 6);
        e.o6 = model_ovf(v, hx, 6);
        e.s2 = model_seg(v, hx, 2);
        e.o2 = model_ovf(v, hx, 2);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; we = 1'b1;
        mem_m[a] = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic settle();
        repeat (50) @(negedge clk);
    endtask

    task automatic wait_busy(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (busy6) seen = 1'b1;
        end
    endtask

    // Counts negedges with busy high for one conversion; 0 when busy never rises
    task automatic measure(output int len);
        bit seen;
        len = 0;
        wait_busy(seen);
        if (seen) begin
            len = 1;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (busy6) len++;
                else break;
            end
        end
    endtask

    task automatic check_sb(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, " seg6"}, {16'hFFFF, seg6}, e.s6);
            chk({nm, " ovf6"}, {63'd0, ovf6}, {63'd0, e.o6});
            chk({nm, " seg2"}, {48'hFFFF_FFFF_FFFF, seg2}, e.s2);
            chk({nm, " ovf2"}, {63'd0, ovf2}, {63'd0, e.o2});
        end
    endtask

    initial begin
        int len;
        bit seen;

        tbl[0] = '{m:1'b0, h:1'b0, a:4'd1,  d:8'h00, e:'{default:'0}};
        tbl[1] = '{m:1'b0, h:1'b1, a:4'd2,  d:8'h2A, e:'{default:'0}};
        tbl[2] = '{m:1'b0, h:1'b0, a:4'd3,  d:8'hFF, e:'{default:'0}};
        tbl[3] = '{m:1'b0, h:1'b1, a:4'd4,  d:8'hFF, e:'{default:'0}};
        tbl[4] = '{m:1'b1, h:1'b1, a:4'd15, d:8'h11, e:'{default:'0}};
        tbl[5] = '{m:1'b1, h:1'b0, a:4'd9,  d:8'h55, e:'{default:'0}};
        tbl[6] = '{m:1'b0, h:1'b0, a:4'd6,  d:8'h64, e:'{default:'0}};
        tbl[7] = '{m:1'b0, h:1'b1, a:4'd8,  d:8'h10, e:'{default:'0}};
        tbl[8] = '{m:1'b0, h:1'b0, a:4'd10, d:8'h07, e:'{default:'0}};
        foreach (tbl[i]) tbl[i].e = model(tbl[i].m ? 32'(tbl[i].a) : 32'(tbl[i].d), tbl[i].h);

        // reset with mem[0] preloaded to 0
        reset = 1'b1; we = 1'b1; address = 4'd0; data_in = 8'h00; mode = 1'b0; hex_mode = 1'b0;
        mem_m[0] = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset seg6", {16'h0, seg6}, {16'h0, 48'hFFFF_FFFF_FFFF});
        chk("reset seg2", {48'h0, seg2}, 64'hFFFF);
        chk("reset busy", {63'd0, busy6}, 64'd0);
        chk("reset ovf", {63'd0, ovf6}, 64'd0);
        we = 1'b0; reset = 1'b0;
        measure(len);
        chk("t1 busy len", 64'(len), 64'd10);
        chk("t1 seg6", {16'h0, seg6}, {16'h0, 48'hFFFF_FFFF_FFC0});

        // decimal data display
        wr(4'd5, 8'h2A);
        settle();
        sb.push_back(model(42, 1'b0));
        check_sb("t2 after write");
        @(negedge clk); address = 4'd0;
        settle();
        @(negedge clk); address = 4'd5;
        measure(len);
        chk("t2 busy len", 64'(len), 64'd10);
        settle();
        chk("t2 seg6", {16'h0, seg6}, {16'h0, 48'hFFFF_FFFF_99A4});

        // hex of the same word
        @(negedge clk); hex_mode = 1'b1;
        measure(len);
        chk("t3 busy len", 64'(len), 64'd3);
        settle();
        chk("t3 seg6", {16'h0, seg6}, {16'h0, 48'hFFFF_FFFF_A488});

        // address display, with the address changed mid-conversion
        @(negedge clk); hex_mode = 1'b0; mode = 1'b1; address = 4'd12;
        settle();
        chk("t4 addr12", {16'h0, seg6}, {16'h0, 48'hFFFF_FFFF_F9A4});
        @(negedge clk); address = 4'd0;
        settle();
        @(negedge clk); address = 4'd12;
        wait_busy(seen);
        repeat (3) @(negedge clk);
        chk("t4 busy mid", {63'd0, busy6}, 64'd1);
        address = 4'd3;
        settle();
        chk("t4 addr3", {16'h0, seg6}, {16'h0, 48'hFFFF_FFFF_FFB0});

        // overflow on the two-digit instance
        @(negedge clk); mode = 1'b0;
        wr(4'd7, 8'hFF);
        settle();
        chk("t5 seg2 255", {48'h0, seg2}, 64'h9292);
        chk("t5 ovf2 255", {63'd0, ovf2}, 64'd1);
        chk("t5 seg6 255", {16'h0, seg6}, {16'h0, 48'hFFFF_FFA4_9292});
        wr(4'd7, 8'h63);
        settle();
        chk("t5 seg2 99", {48'h0, seg2}, 64'h9090);
        chk("t5 ovf2 99", {63'd0, ovf2}, 64'd0);

        // table of vectors through the scoreboard
        foreach (tbl[i]) begin
            @(negedge clk); mode = tbl[i].m; hex_mode = tbl[i].h;
            wr(tbl[i].a, tbl[i].d);
            sb.push_back(tbl[i].e);
            settle();
            check_sb($sformatf("vec%0d", i));
        end

        // reset in the middle of a conversion
        @(negedge clk); mode = 1'b0; hex_mode = 1'b0; address = 4'd7;
        settle();
        @(negedge clk); address = 4'd5;
        wait_busy(seen);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6 seg6 in reset", {16'h0, seg6}, {16'h0, 48'hFFFF_FFFF_FFFF});
        chk("t6 busy in reset", {63'd0, busy6}, 64'd0);
        @(negedge clk); reset = 1'b0;
        sb.push_back(model(32'(mem_m[5]), 1'b0));
        settle();
        check_sb("t6 rebuilt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
